// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer core.
// Hour digits are only active when COUNTDOWN_HOURS_EN is defined.
package countdown_pkg;

    typedef enum logic [1:0] {
        StSet   = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } cd_state_e;

    localparam int        NUM_DIGITS = 6;
    localparam logic [3:0] SEP        = 4'hb;
    localparam logic [31:0] RESET_WORD = 32'h00b00b00;

    localparam logic [3:0] MAX_S_ONES = 4'd9;
    localparam logic [3:0] MAX_S_TENS = 4'd5;
    localparam logic [3:0] MAX_M_ONES = 4'd9;
    localparam logic [3:0] MAX_M_TENS = 4'd5;
    localparam logic [3:0] MAX_H_ONES = 4'd9;
    localparam logic [3:0] MAX_H_TENS = 4'd9;

    localparam logic [3:0] SEL_NONE   = 4'd0;
    localparam logic [3:0] SEL_S_ONES = 4'd1;
    localparam logic [3:0] SEL_S_TENS = 4'd2;
    localparam logic [3:0] SEL_M_ONES = 4'd3;
    localparam logic [3:0] SEL_M_TENS = 4'd4;
    localparam logic [3:0] SEL_H_ONES = 4'd5;
    localparam logic [3:0] SEL_H_TENS = 4'd6;

    // Digit index 0 is S ones, 5 is H tens.
    function automatic logic [3:0] digit_max(input int idx);
        case (idx)
            0:       return MAX_S_ONES;
            1:       return MAX_S_TENS;
            2:       return MAX_M_ONES;
            3:       return MAX_M_TENS;
            4:       return MAX_H_ONES;
            default: return MAX_H_TENS;
        endcase
    endfunction

    function automatic logic [3:0] digit_inc(input logic [3:0] val, input logic [3:0] max);
        return (val >= max) ? 4'd0 : val + 4'd1;
    endfunction

    function automatic logic [31:0] pack_time(input logic [5:0][3:0] d);
        return {d[5], d[4], SEP, d[3], d[2], SEP, d[1], d[0]};
    endfunction

endpackage

// File: rtl/cd_bcd_digit.sv
// One BCD decade of the running count: load, borrow-driven decrement and increment-wrap.
// Borrow out is combinational so a chain of digits decrements in a single cycle.
module cd_bcd_digit #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_borrow_in,
    input  logic       i_inc,
    output logic       o_borrow_out,
    output logic [3:0] o_val
);

    logic [3:0] r_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val <= 4'd0;
        end else if (i_load) begin
            r_val <= i_load_val;
        end else if (i_borrow_in) begin
            r_val <= (r_val == 4'd0) ? MAX : r_val - 4'd1;
        end else if (i_inc) begin
            r_val <= (r_val >= MAX) ? 4'd0 : r_val + 4'd1;
        end
    end

    assign o_borrow_out = i_borrow_in && (r_val == 4'd0);
    assign o_val        = r_val;

endmodule

// File: rtl/countdown_core.sv
// Countdown timer control: preset editing, BCD countdown and SET/RUN/PAUSE/DONE sequencing.
// COUNTDOWN_HOURS_EN enables the hour digits; otherwise they are held at zero.
module countdown_core
    import countdown_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic        btn_start,
    input  logic        btn_clr,
    output logic [31:0] tmp,
    output logic [31:0] tmp1,
    output logic [3:0]  state,
    output logic        go,
    output logic        finish
);

`ifdef COUNTDOWN_HOURS_EN
    localparam int         NUM_ACTIVE = 6;
    localparam logic [3:0] SEL_LAST   = SEL_H_TENS;
`else
    localparam int         NUM_ACTIVE = 4;
    localparam logic [3:0] SEL_LAST   = SEL_M_TENS;
`endif

    logic r_sel_prev, r_inc_prev, r_start_prev, r_clr_prev;
    logic w_ev_sel, w_ev_inc, w_ev_start, w_ev_clr;

    cd_state_e        r_fsm;
    logic [3:0]       r_state;
    logic             r_go;
    logic             r_finish;
    logic [5:0][3:0]  r_pre;
    logic [5:0][3:0]  w_cnt;
    logic [5:0]       w_bin;
    logic [5:0]       w_bout;

    logic w_pre_nz, w_start_run, w_load, w_dec, w_last, w_underflow;
    logic w_set_idle, w_inc_ok, w_sel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_prev   <= 1'b0;
            r_inc_prev   <= 1'b0;
            r_start_prev <= 1'b0;
            r_clr_prev   <= 1'b0;
        end else begin
            r_sel_prev   <= btn_sel;
            r_inc_prev   <= btn_inc;
            r_start_prev <= btn_start;
            r_clr_prev   <= btn_clr;
        end
    end

    assign w_ev_sel   = btn_sel   & ~r_sel_prev;
    assign w_ev_inc   = btn_inc   & ~r_inc_prev;
    assign w_ev_start = btn_start & ~r_start_prev;
    assign w_ev_clr   = btn_clr   & ~r_clr_prev;

    assign w_pre_nz    = |r_pre;
    assign w_start_run = w_ev_start && !w_ev_clr && (r_fsm == StSet) && w_pre_nz;
    assign w_load      = w_ev_clr || w_start_run;
    // A start press in RUN pauses and swallows a coincident tick.
    assign w_dec       = (r_fsm == StRun) && tick && !w_ev_start && !w_ev_clr;
    assign w_last      = (w_cnt[0] == 4'd1) && (w_cnt[5:1] == '0);
    assign w_underflow = |w_bout[5:NUM_ACTIVE-1];

    // Any higher-priority event in the same cycle consumes it.
    assign w_set_idle = (r_fsm == StSet) && !w_ev_start && !w_ev_clr;
    assign w_inc_ok   = w_set_idle && w_ev_inc && (r_state != SEL_NONE);
    assign w_sel_ok   = w_set_idle && w_ev_sel && !w_ev_inc;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [3:0] w_load_val;

        if (i == 0) begin : g_bin_first
            assign w_bin[i] = w_dec;
        end else if (i < NUM_ACTIVE) begin : g_bin_chain
            assign w_bin[i] = w_bout[i-1];
        end else begin : g_bin_off
            assign w_bin[i] = 1'b0;
        end

        assign w_load_val = w_ev_clr ? 4'd0 : r_pre[i];

        cd_bcd_digit #(
            .MAX (digit_max(i))
        ) u_digit (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_load       (w_load),
            .i_load_val   (w_load_val),
            .i_borrow_in  (w_bin[i]),
            .i_inc        (1'b0),
            .o_borrow_out (w_bout[i]),
            .o_val        (w_cnt[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_inc_ok && (r_state == 4'(i + 1)) && (i < NUM_ACTIVE)) begin
                    r_pre[i] <= digit_inc(r_pre[i], digit_max(i));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm    <= StSet;
            r_state  <= SEL_NONE;
            r_go     <= 1'b0;
            r_finish <= 1'b0;
        end else if (w_ev_clr) begin
            r_fsm    <= StSet;
            r_state  <= SEL_NONE;
            r_go     <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            case (r_fsm)
                StSet: begin
                    if (w_start_run) begin
                        r_fsm   <= StRun;
                        r_state <= SEL_NONE;
                        r_go    <= 1'b1;
                    end else if (w_sel_ok) begin
                        r_state <= (r_state == SEL_LAST) ? SEL_S_ONES : r_state + 4'd1;
                    end
                end
                StRun: begin
                    if (w_ev_start) begin
                        r_fsm <= StPause;
                    end else if (w_dec && (w_last || w_underflow)) begin
                        r_fsm    <= StDone;
                        r_finish <= 1'b1;
                    end
                end
                StPause: begin
                    if (w_ev_start) begin
                        r_fsm <= StRun;
                    end
                end
                StDone: begin
                    if (w_ev_start) begin
                        r_fsm    <= StSet;
                        r_go     <= 1'b0;
                        r_finish <= 1'b0;
                    end
                end
                default: r_fsm <= StSet;
            endcase
        end
    end

    assign tmp    = pack_time(w_cnt);
    assign tmp1   = pack_time(r_pre);
    assign state  = r_state;
    assign go     = r_go;
    assign finish = r_finish;

endmodule

// File: tb/tb_countdown_core.sv
// Self-checking bench for countdown_core: directed scenarios plus random button/tick traffic,
// all compared every cycle against a seconds-based reference model.
module tb_countdown_core;

`ifdef COUNTDOWN_HOURS_EN
    localparam int SEL_LAST = 6;
`else
    localparam int SEL_LAST = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tick = 1'b0;
    logic        btn_sel = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_clr = 1'b0;
    logic [31:0] tmp, tmp1;
    logic [3:0]  state;
    logic        go, finish;

    always #5 clk = ~clk;

    countdown_core u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .btn_sel   (btn_sel),
        .btn_inc   (btn_inc),
        .btn_start (btn_start),
        .btn_clr   (btn_clr),
        .tmp       (tmp),
        .tmp1      (tmp1),
        .state     (state),
        .go        (go),
        .finish    (finish)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0=SET 1=RUN 2=PAUSE 3=DONE; running value kept as plain seconds.
    int m_mode;
    int m_secs;
    int m_sel;
    int m_pre[6];
    bit m_prev_sel, m_prev_inc, m_prev_start, m_prev_clr;

    function automatic int dmax(input int i);
        case (i)
            1, 3:    return 5;
            default: return 9;
        endcase
    endfunction

    function automatic logic [31:0] fmt(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'hb, 4'(m / 10), 4'(m % 10), 4'hb, 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [31:0] fmt_secs(input int secs);
        return fmt(secs / 3600, (secs / 60) % 60, secs % 60);
    endfunction

    function automatic int pre_secs();
        return (m_pre[5] * 10 + m_pre[4]) * 3600 + (m_pre[3] * 10 + m_pre[2]) * 60
               + m_pre[1] * 10 + m_pre[0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_secs = 0;
        m_sel  = 0;
        for (int i = 0; i < 6; i++) m_pre[i] = 0;
        m_prev_sel = 0; m_prev_inc = 0; m_prev_start = 0; m_prev_clr = 0;
    endtask

    task automatic model_step();
        bit e_sel, e_inc, e_start, e_clr;
        e_sel   = btn_sel   && !m_prev_sel;
        e_inc   = btn_inc   && !m_prev_inc;
        e_start = btn_start && !m_prev_start;
        e_clr   = btn_clr   && !m_prev_clr;
        m_prev_sel = btn_sel; m_prev_inc = btn_inc;
        m_prev_start = btn_start; m_prev_clr = btn_clr;
        if (e_clr) begin
            m_secs = 0; m_mode = 0; m_sel = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (e_start) begin
                        if (pre_secs() != 0) begin
                            m_secs = pre_secs(); m_mode = 1; m_sel = 0;
                        end
                    end else if (e_inc) begin
                        if (m_sel != 0) m_pre[m_sel-1] = (m_pre[m_sel-1] + 1) % (dmax(m_sel-1) + 1);
                    end else if (e_sel) begin
                        m_sel = (m_sel == SEL_LAST) ? 1 : m_sel + 1;
                    end
                end
                1: begin
                    if (e_start) m_mode = 2;
                    else if (tick) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) m_mode = 3;
                    end
                end
                2: if (e_start) m_mode = 1;
                default: if (e_start) m_mode = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        check("tmp", tmp, fmt_secs(m_secs));
        check("tmp1", tmp1, fmt(m_pre[5] * 10 + m_pre[4], m_pre[3] * 10 + m_pre[2],
                                m_pre[1] * 10 + m_pre[0]));
        check("state", 32'(state), 32'(m_sel));
        check("go", 32'(go), 32'(m_mode != 0));
        check("finish", 32'(finish), 32'(m_mode == 3));
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       btn_sel = v;
            1:       btn_inc = v;
            2:       btn_start = v;
            default: btn_clr = v;
        endcase
    endtask

    task automatic press(input int which, input int times);
        for (int k = 0; k < times; k++) begin
            set_btn(which, 1'b1);
            cycle();
            set_btn(which, 1'b0);
            cycle();
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            cycle();
        end
        tick = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tmp"}, tmp, 32'h00b00b00);
        check({tag, "_tmp1"}, tmp1, 32'h00b00b00);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_go"}, 32'(go), 32'd0);
        check({tag, "_finish"}, 32'(finish), 32'd0);
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // S ones = 3, run to zero
        press(0, 1);
        press(1, 3);
        press(2, 1);
        check("start_tmp1", tmp1, 32'h00b00b03);
        check("start_tmp", tmp, 32'h00b00b03);
        check("start_go", 32'(go), 32'd1);
        ticks(3);
        check("zero_tmp", tmp, 32'h00b00b00);
        check("zero_finish", 32'(finish), 32'd1);
        press(2, 1);
        check("ack_go", 32'(go), 32'd0);

        // Preset 00:01:00, borrow across separator
        press(0, 1);
        press(1, 7);
        press(0, 2);
        press(1, 1);
        check("preset_0100", tmp1, 32'h00b01b00);
        press(2, 1);
        ticks(1);
        check("borrow_tmp", tmp, 32'h00b00b59);

        // Start and tick together pause, ticks then ignored
        btn_start = 1'b1; tick = 1'b1;
        cycle();
        btn_start = 1'b0; tick = 1'b0;
        check("pause_tmp", tmp, 32'h00b00b59);
        ticks(3);
        check("paused_tmp", tmp, 32'h00b00b59);
        check("paused_go", 32'(go), 32'd1);
        press(2, 1);
        ticks(1);
        check("resume_tmp", tmp, 32'h00b00b58);

        // Clear, then start with an all-zero preset is ignored
        press(3, 1);
        press(0, 3);
        press(1, 9);
        press(2, 1);
        check("zero_start_go", 32'(go), 32'd0);

        // M tens wrap and selector wrap
        press(0, 1);
        press(1, 5);
        check("mtens5", tmp1, 32'h00b50b00);
        press(1, 1);
        check("mtens_wrap", tmp1, 32'h00b00b00);
        press(3, 1);
        press(0, SEL_LAST);
        check("sel_last", 32'(state), 32'(SEL_LAST));
        press(0, 1);
        check("sel_wrap", 32'(state), 32'd1);

        // 12:34 then clear in RUN
        press(1, 4);
        press(0, 1); press(1, 3);
        press(0, 1); press(1, 2);
        press(0, 1); press(1, 1);
        press(2, 1);
        check("run_1234", tmp, 32'h00b12b34);
        press(3, 1);
        check("clr_tmp", tmp, 32'h00b00b00);
        check("clr_go", 32'(go), 32'd0);
        check("clr_tmp1", tmp1, 32'h00b12b34);

        // Asynchronous reset mid-run
        press(2, 1);
        ticks(5);
        #3 rst_n = 1'b0;
        #1 check_reset_values("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int it = 0; it < 1500; it++) begin
            int r, which, hold;
            r = int'($urandom_range(0, 99));
            if (r < 2) which = 3;
            else if (r < 17) which = 2;
            else if (r < 47) which = 1;
            else if (r < 67) which = 0;
            else which = -1;
            hold = int'($urandom_range(1, 3));
            for (int h = 0; h < hold; h++) begin
                if (which >= 0) set_btn(which, 1'b1);
                tick = ($urandom_range(0, 99) < 40);
                cycle();
            end
            if (which >= 0) set_btn(which, 1'b0);
            tick = ($urandom_range(0, 99) < 40);
            cycle();
        end
        tick = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
